// File: rtl/sirv_expl_icb2axi_mst.sv
// Single-outstanding ICB-to-AXI master bridge: one ICB command becomes one single-beat
// AXI read or write, and its response is returned before the next command is taken.
module sirv_expl_icb2axi_mst #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [AW-1:0]     icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [DW-1:0]     icb_cmd_wdata,
    input  logic [DW/8-1:0]   icb_cmd_wmask,

    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic [DW-1:0]     icb_rsp_rdata,
    output logic              icb_rsp_err,

    output logic              axi_arvalid,
    input  logic              axi_arready,
    output logic [AW-1:0]     axi_araddr,
    output logic              axi_arcache,
    output logic              axi_arprot,
    output logic              axi_arlock,
    output logic [1:0]        axi_arburst,
    output logic [7:0]        axi_arlen,
    output logic [2:0]        axi_arsize,

    input  logic              axi_rvalid,
    input  logic [DW-1:0]     axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rlast,
    output logic              axi_rready,

    output logic              axi_awvalid,
    input  logic              axi_awready,
    output logic [AW-1:0]     axi_awaddr,
    output logic              axi_awcache,
    output logic              axi_awprot,
    output logic              axi_awlock,
    output logic [1:0]        axi_awburst,
    output logic [7:0]        axi_awlen,
    output logic [2:0]        axi_awsize,

    output logic              axi_wvalid,
    input  logic              axi_wready,
    output logic [DW-1:0]     axi_wdata,
    output logic [DW/8-1:0]   axi_wstrb,
    output logic              axi_wlast,

    input  logic              axi_bvalid,
    input  logic [1:0]        axi_bresp,
    output logic              axi_bready
);

    localparam logic [2:0] BeatSize = 3'($clog2(DW / 8));

    typedef enum logic [1:0] {StIdle, StRd, StWr, StRsp} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   wmask_q, wmask_d;
    logic              arvalid_q, arvalid_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              b_done_q, b_done_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              ar_hs, aw_hs, w_hs, b_hs;
    logic              unused_rlast;

    // Single-beat transfers make rlast redundant.
    assign unused_rlast = axi_rlast;

    assign ar_hs = arvalid_q & axi_arready;
    assign aw_hs = awvalid_q & axi_awready;
    assign w_hs  = wvalid_q & axi_wready;
    assign b_hs  = axi_bvalid & ~b_done_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        arvalid_d   = arvalid_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        b_done_d    = b_done_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;

        unique case (state_q)
            StIdle: begin
                if (icb_cmd_valid) begin
                    addr_d  = icb_cmd_addr;
                    wdata_d = icb_cmd_wdata;
                    wmask_d = icb_cmd_wmask;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (icb_cmd_read) begin
                        state_d   = StRd;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = StWr;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        b_done_d  = 1'b0;
                    end
                end
            end
            StRd: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                end
                // R may arrive with or even before AR; either way the read is complete.
                if (axi_rvalid) begin
                    rdata_d     = axi_rdata;
                    err_d       = |axi_rresp;
                    arvalid_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StRsp;
                end
            end
            StWr: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (b_hs) begin
                    b_done_d = 1'b1;
                    err_d    = |axi_bresp;
                end
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs) && (b_done_q | b_hs)) begin
                    rsp_valid_d = 1'b1;
                    state_d     = StRsp;
                end
            end
            StRsp: begin
                if (icb_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            arvalid_q   <= arvalid_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            b_done_q    <= b_done_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign icb_cmd_ready = (state_q == StIdle);
    assign icb_rsp_valid = rsp_valid_q;
    assign icb_rsp_rdata = rdata_q;
    assign icb_rsp_err   = err_q;

    assign axi_arvalid = arvalid_q;
    assign axi_araddr  = addr_q;
    assign axi_arcache = 1'b0;
    assign axi_arprot  = 1'b0;
    assign axi_arlock  = 1'b0;
    assign axi_arburst = 2'b01;
    assign axi_arlen   = 8'd0;
    assign axi_arsize  = BeatSize;
    assign axi_rready  = (state_q == StRd);

    assign axi_awvalid = awvalid_q;
    assign axi_awaddr  = addr_q;
    assign axi_awcache = 1'b0;
    assign axi_awprot  = 1'b0;
    assign axi_awlock  = 1'b0;
    assign axi_awburst = 2'b01;
    assign axi_awlen   = 8'd0;
    assign axi_awsize  = BeatSize;

    assign axi_wvalid  = wvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wmask_q;
    assign axi_wlast   = 1'b1;
    assign axi_bready  = (state_q == StWr);

endmodule

// File: tb/tb_sirv_expl_icb2axi_mst.sv
// Bench for sirv_expl_icb2axi_mst: directed vector table, randomized transactions against a
// byte-memory reference model, and an asynchronous reset sequence.
module tb_sirv_expl_icb2axi_mst;

    logic        clk = 1'b0;
    logic        rst;
    logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [31:0] icb_cmd_addr, icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
    logic [31:0] icb_rsp_rdata;
    logic        axi_arvalid, axi_arready, axi_arcache, axi_arprot, axi_arlock;
    logic [31:0] axi_araddr;
    logic [1:0]  axi_arburst;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic        axi_rvalid, axi_rlast, axi_rready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_awvalid, axi_awready, axi_awcache, axi_awprot, axi_awlock;
    logic [31:0] axi_awaddr;
    logic [1:0]  axi_awburst;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic        axi_wvalid, axi_wready, axi_wlast;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid, axi_bready;
    logic [1:0]  axi_bresp;

    always #5 clk = ~clk;

    sirv_expl_icb2axi_mst #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arlock(axi_arlock),
        .axi_arburst(axi_arburst), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rready(axi_rready),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awlock(axi_awlock),
        .axi_awburst(axi_awburst), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bready(axi_bready)
    );

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          ar_d, r_d, aw_d, w_d, b_d, rsp_d;
        int          lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] resp_of(input logic [31:0] a);
        case (a[31:28])
            4'hE:    return 2'b10;
            4'hF:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
    endfunction

    // Runs one transaction starting at a negedge; acts as ICB master and as the AXI slave.
    task automatic run_txn(input vec_t v, input string nm);
        logic        ar_hs, r_hs, aw_hs, w_hs, b_hs, done, proto;
        logic        ar_now, r_now, aw_now, w_now, b_now, rsp_now;
        logic [31:0] cap_awaddr, cap_wdata, s_rdata;
        logic [3:0]  cap_strb;
        logic        s_err;
        int          lat, hold, k, w;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; done = 0; proto = 1;
        cap_awaddr = 0; cap_wdata = 0; cap_strb = 0; s_rdata = 0; s_err = 0;
        lat = -1; hold = 0;

        if (!v.rd) ref_mem[v.addr] = merge(ref_rd(v.addr), v.wdata, v.wmask);

        icb_cmd_valid = 1; icb_cmd_read = v.rd; icb_cmd_addr = v.addr;
        icb_cmd_wdata = v.wdata; icb_cmd_wmask = v.wmask;
        w = 0;
        while (!icb_cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({nm, " cmd_ready"}, 64'(icb_cmd_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        icb_cmd_valid = 0;

        for (int c = 1; c < 40 && !done; c++) begin
            k = c - 1;
            if (lat < 0 && icb_rsp_valid) begin
                lat = c; s_rdata = icb_rsp_rdata; s_err = icb_rsp_err;
            end
            if (lat >= 0) begin
                if (!icb_rsp_valid || icb_rsp_rdata !== s_rdata || icb_rsp_err !== s_err
                    || icb_cmd_ready) proto = 0;
                icb_rsp_ready = (hold >= v.rsp_d);
                hold++;
            end else begin
                icb_rsp_ready = 0;
                if (icb_cmd_ready) proto = 0;
                if (v.rd) begin
                    if (!axi_rready || axi_bready || axi_awvalid || axi_wvalid) proto = 0;
                    if (axi_arvalid !== !ar_hs) proto = 0;
                end else begin
                    if (!axi_bready || axi_rready || axi_arvalid) proto = 0;
                    if (axi_awvalid !== !aw_hs || axi_wvalid !== !w_hs) proto = 0;
                end
            end
            if (axi_arvalid && axi_araddr !== v.addr) proto = 0;
            if (axi_awvalid && axi_awaddr !== v.addr) proto = 0;
            if (axi_wvalid && {axi_wdata, axi_wstrb, axi_wlast} !== {v.wdata, v.wmask, 1'b1})
                proto = 0;

            axi_arready = axi_arvalid && !ar_hs && k >= v.ar_d;
            axi_rvalid  = v.rd && !r_hs && lat < 0 && k >= v.r_d;
            axi_rdata   = axi_rvalid ? slv_rd(v.addr) : $urandom();
            axi_rresp   = resp_of(v.addr);
            axi_rlast   = 1;
            axi_awready = axi_awvalid && !aw_hs && k >= v.aw_d;
            axi_wready  = axi_wvalid && !w_hs && k >= v.w_d;
            axi_bvalid  = !v.rd && !b_hs && (w_hs || (axi_wvalid && axi_wready)) && k >= v.b_d;
            axi_bresp   = resp_of(v.addr);

            ar_now  = axi_arvalid && axi_arready;
            r_now   = axi_rvalid && axi_rready;
            aw_now  = axi_awvalid && axi_awready;
            w_now   = axi_wvalid && axi_wready;
            b_now   = axi_bvalid && axi_bready;
            rsp_now = icb_rsp_valid && icb_rsp_ready;
            @(posedge clk);
            if (ar_now) ar_hs = 1;
            if (r_now) r_hs = 1;
            if (aw_now) begin aw_hs = 1; cap_awaddr = axi_awaddr; end
            if (w_now) begin w_hs = 1; cap_wdata = axi_wdata; cap_strb = axi_wstrb; end
            if (b_now) b_hs = 1;
            if (rsp_now) done = 1;
            @(negedge clk);
        end

        if (aw_hs && w_hs) slv_mem[cap_awaddr] = merge(slv_rd(cap_awaddr), cap_wdata, cap_strb);
        axi_arready = 0; axi_rvalid = 0; axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
        icb_rsp_ready = 0;
        if (done && (!icb_cmd_ready || icb_rsp_valid)) proto = 0;

        check({nm, " done"}, 64'(done), 64'd1);
        check({nm, " rdata"}, 64'(s_rdata), 64'(v.exp_rdata));
        check({nm, " err"}, 64'(s_err), 64'(v.exp_err));
        if (v.lat >= 0) check({nm, " latency"}, 64'(lat), 64'(v.lat));
        check({nm, " protocol"}, 64'(proto), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t  tbl [12];
        vec_t  rv;
        logic [31:0] addrs [6];
        int    w;

        tbl[0]  = '{1'b1, 32'h0000_1000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_2004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 32'h0000_3000, 32'h1234_5678, 4'hF, 0, 0, 4, 0, 0, 0, 6, 32'h0, 1'b0};
        tbl[3]  = '{1'b0, 32'hE000_0100, 32'h55AA_55AA, 4'hF, 0, 0, 0, 0, 0, 0, 2, 32'h0, 1'b1};
        tbl[4]  = '{1'b1, 32'hE000_0100, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2, 32'h55AA_55AA, 1'b1};
        tbl[5]  = '{1'b1, 32'h0000_2004, 32'h0, 4'h0, 0, 0, 0, 0, 0, 5, 2, 32'hDEAD_BEEF, 1'b0};
        tbl[6]  = '{1'b0, 32'h0000_2004, 32'h1122_3344, 4'h5, 0, 0, 0, 0, 0, 0, 2, 32'h0, 1'b0};
        tbl[7]  = '{1'b1, 32'h0000_2004, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2, 32'hDE22_BE44, 1'b0};
        tbl[8]  = '{1'b1, 32'h0000_2004, 32'h0, 4'h0, 3, 1, 0, 0, 0, 0, 3, 32'hDE22_BE44, 1'b0};
        tbl[9]  = '{1'b1, 32'hF000_0000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2, 32'h0, 1'b1};
        tbl[10] = '{1'b0, 32'h0000_3000, 32'hCAFE_F00D, 4'h3, 0, 0, 1, 2, 3, 0, 5, 32'h0, 1'b0};
        tbl[11] = '{1'b1, 32'h0000_3000, 32'h0, 4'h0, 0, 2, 0, 0, 0, 0, 4, 32'h1234_F00D, 1'b0};

        icb_cmd_valid = 0; icb_cmd_read = 0; icb_cmd_addr = 0; icb_cmd_wdata = 0;
        icb_cmd_wmask = 0; icb_rsp_ready = 0;
        axi_arready = 0; axi_rvalid = 0; axi_rdata = 0; axi_rresp = 0; axi_rlast = 0;
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
        rst = 0;
        #1 rst = 1;
        repeat (2) @(negedge clk);
        check("reset outputs",
              {axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready,
               icb_rsp_valid, icb_rsp_err, icb_rsp_rdata}, 64'd0);
        rst = 0;
        @(negedge clk);
        check("cmd_ready after reset", 64'(icb_cmd_ready), 64'd1);
        check("axi constants",
              {axi_arcache, axi_arprot, axi_arlock, axi_arburst, axi_arlen, axi_arsize,
               axi_awcache, axi_awprot, axi_awlock, axi_awburst, axi_awlen, axi_awsize},
              {3'b000, 2'b01, 8'd0, 3'd2, 3'b000, 2'b01, 8'd0, 3'd2});

        for (int i = 0; i < 12; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        addrs[0] = 32'h0000_0100; addrs[1] = 32'h0000_0104; addrs[2] = 32'h0000_0108;
        addrs[3] = 32'h0000_010C; addrs[4] = 32'hE000_0010; addrs[5] = 32'hF000_0020;
        for (int i = 0; i < 150; i++) begin
            rv.rd    = 1'($urandom_range(0, 1));
            rv.addr  = addrs[$urandom_range(0, 5)];
            rv.wdata = $urandom();
            rv.wmask = 4'($urandom_range(0, 15));
            rv.ar_d  = $urandom_range(0, 3);
            rv.r_d   = $urandom_range(0, 3);
            rv.aw_d  = $urandom_range(0, 3);
            rv.w_d   = $urandom_range(0, 3);
            rv.b_d   = $urandom_range(0, 3);
            rv.rsp_d = $urandom_range(0, 2);
            rv.lat   = -1;
            rv.exp_rdata = rv.rd ? ref_rd(rv.addr) : 32'h0;
            rv.exp_err   = (resp_of(rv.addr) != 2'b00);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        // Reset while a read is waiting for arready: everything drops, nothing is answered.
        icb_cmd_valid = 1; icb_cmd_read = 1; icb_cmd_addr = 32'h0000_4000;
        w = 0;
        while (!icb_cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        icb_cmd_valid = 0;
        check("rst pre arvalid", 64'(axi_arvalid), 64'd1);
        #1 rst = 1;
        #1 check("rst async drop", {axi_arvalid, axi_rready}, 64'd0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst idle %0d", i), {icb_cmd_ready, icb_rsp_valid, axi_arvalid},
                  64'b100);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
